// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive queue: default geometry and the status
// word that the register block exposes.
package uart_rx_fifo_pkg;

    localparam int UART_RXQ_DEPTH  = 16;
    localparam int UART_RXQ_THRESH = 8;
    localparam int UART_RXQ_LVL_W  = $clog2(UART_RXQ_DEPTH) + 1;

    typedef struct packed {
        logic                      overrun;
        logic                      full;
        logic                      empty;
        logic [UART_RXQ_LVL_W-1:0] level;
    } uart_rxq_status_t;

    function automatic uart_rxq_status_t rxq_status(
        input logic                      overrun,
        input logic                      full,
        input logic                      empty,
        input logic [UART_RXQ_LVL_W-1:0] level
    );
        uart_rxq_status_t s;
        s.overrun = overrun;
        s.full    = full;
        s.empty   = empty;
        s.level   = level;
        return s;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH storage with synchronous write and asynchronous read, shared by the
// UART receive and transmit queues.
module uart_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; validity is tracked entirely by the pointers and level,
    // so the array maps onto distributed RAM. State updates use <= so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte queue between uart_rx and the mmio read path: show-ahead head byte,
// occupancy flags, sticky overrun, saturating drop counter and a level interrupt.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = UART_RXQ_DEPTH,
    parameter int THRESH = UART_RXQ_THRESH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_data_valid,
    input  logic [7:0]        rx_data,
    input  logic              pop,
    input  logic              clr_overrun,
    output logic [7:0]        rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic              overrun,
    output logic [7:0]        drop_cnt,
    output logic              thresh_irq
);

    localparam logic [ADDR_W:0] DEPTH_L  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] THRESH_L = THRESH[ADDR_W:0];

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [7:0]        mem_rdata;
    logic              push_ok;
    logic              pop_ok;
    logic              drop;
    logic [ADDR_W:0]   level_next;
    logic [7:0]        drop_cnt_next;

    assign empty      = (level == '0);
    assign full       = (level == DEPTH_L);
    assign thresh_irq = (level >= THRESH_L);
    assign rd_data    = empty ? 8'h00 : mem_rdata;

    // A pop frees a slot in the same cycle, so a full queue still accepts a write alongside it.
    assign push_ok = rx_data_valid && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign drop    = rx_data_valid && full && !pop;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (8),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk  (clk),
        .we   (push_ok),
        .waddr(wr_ptr),
        .wdata(rx_data),
        .raddr(rd_ptr),
        .rdata(mem_rdata)
    );

    // NOTE: every signal written here gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        level_next    = level;
        drop_cnt_next = drop_cnt;
        case ({push_ok, pop_ok})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
        if (drop) begin
            if (clr_overrun) begin
                drop_cnt_next = 8'h01;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt_next = drop_cnt + 1'b1;
            end
        end else if (clr_overrun) begin
            drop_cnt_next = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overrun  <= 1'b0;
            drop_cnt <= 8'h00;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level    <= level_next;
            drop_cnt <= drop_cnt_next;
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    logic [ADDR_W-1:0] ptr_diff;
    assign ptr_diff = wr_ptr - rd_ptr;

    always @(posedge clk) begin
        if (!rst) begin
            assert (level <= DEPTH_L)
                else $error("uart_rx_fifo: level %0d exceeds depth", level);
            assert (ptr_diff == level[ADDR_W-1:0])
                else $error("uart_rx_fifo: pointer distance %0d disagrees with level %0d",
                            ptr_diff, level);
            assert (!(empty && full))
                else $error("uart_rx_fifo: empty and full together");
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a reference model predicts flags, and a scoreboard
// queue holds expected bytes that a monitor compares whenever a pop is accepted.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int THRESH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_data_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       pop = 1'b0;
    logic       clr_overrun = 1'b0;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       overrun;
    logic [7:0] drop_cnt;
    logic       thresh_irq;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    int         m_level   = 0;
    logic       m_overrun = 1'b0;
    int         m_drop    = 0;

    uart_rx_fifo #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data_valid(rx_data_valid),
        .rx_data      (rx_data),
        .pop          (pop),
        .clr_overrun  (clr_overrun),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .level        (level),
        .overrun      (overrun),
        .drop_cnt     (drop_cnt),
        .thresh_irq   (thresh_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: an accepted pop presents the head byte, which must match the scoreboard front.
    always @(negedge clk) begin
        if (!rst && pop && !empty) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", exp_q.size(), 1);
            end else begin
                check("sb_data", rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic check_state();
        check("level", level, m_level);
        check("empty", empty, m_level == 0);
        check("full", full, m_level == DEPTH);
        check("thresh_irq", thresh_irq, m_level >= THRESH);
        check("overrun", overrun, m_overrun);
        check("drop_cnt", drop_cnt, m_drop);
        if (m_level == 0) check("rd_data_empty", rd_data, 8'h00);
    endtask

    // One clock of stimulus; the model predicts the post-edge state.
    task automatic cycle(input logic v, input logic [7:0] d, input logic p, input logic c);
        logic push_ok, pop_ok, drop;
        rx_data_valid = v;
        rx_data       = d;
        pop           = p;
        clr_overrun   = c;
        pop_ok  = p && (m_level != 0);
        push_ok = v && ((m_level < DEPTH) || p);
        drop    = v && (m_level == DEPTH) && !p;
        if (push_ok) exp_q.push_back(d);
        m_level = m_level + int'(push_ok) - int'(pop_ok);
        if (drop) begin
            m_overrun = 1'b1;
            m_drop    = c ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
        end else if (c) begin
            m_overrun = 1'b0;
            m_drop    = 0;
        end
        @(posedge clk);
        #1;
        rx_data_valid = 1'b0;
        pop           = 1'b0;
        clr_overrun   = 1'b0;
        check_state();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        m_level   = 0;
        m_overrun = 1'b0;
        m_drop    = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_state();
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && m_level > 0; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // 1: single byte, one-cycle show-ahead latency
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        check("t1_rd_data", rd_data, 8'hA5);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("t1_rd_data_after_pop", rd_data, 8'h00);

        // 2: fill to full, then drain in order
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        drain();

        // 3: drops on a full queue, clear racing a drop, saturation
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
        check("t3_drop_cnt3", drop_cnt, 8'd3);
        cycle(1'b1, 8'hE3, 1'b0, 1'b1);
        check("t3_clr_vs_drop", drop_cnt, 8'd1);
        for (int i = 0; i < 260; i++) cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        check("t3_saturate", drop_cnt, 8'hFF);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // 4: push and pop together on full, then on empty
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        drain();
        cycle(1'b1, 8'h66, 1'b1, 1'b0);
        check("t4_empty_push_pop_level", level, 5'd1);
        drain();

        // 5: wrap with level held between 3 and 5, then pops on empty
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            case (i % 3)
                0: cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
                1: begin
                    cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
                    cycle(1'b0, 8'h00, 1'b1, 1'b0);
                end
                default: begin
                    cycle(1'b0, 8'h00, 1'b1, 1'b0);
                    cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
                end
            endcase
        end
        drain();
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // 6: reset mid-stream discards contents and clears flags
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hBB, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH - 7; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("t6_level7", level, 5'd7);
        do_reset();
        cycle(1'b1, 8'hC3, 1'b0, 1'b0);
        check("t6_rd_after_reset", rd_data, 8'hC3);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        check("sb_leftover", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
